// File: rtl/skolem_sweep_ctrl_pkg.sv
// Shared types and helpers for the Skolem sweep controller.
//   sweep_state_t : controller state encoding
//   cnt_width()   : result-counter width able to hold 2^n
//   SETTLE_MIN    : smallest legal settle time per WAIT state
package skolem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSk,
    StWaitPhi,
    StWaitAlt,
    StNext,
    StDone
  } sweep_state_t;

  localparam int unsigned SETTLE_MIN = 1;

  // One extra bit so a full sweep of 2^n points never wraps.
  function automatic int unsigned cnt_width(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/skolem_sweep_ctrl_if.sv
// Evaluation bus between the sweep controller and the external blocks.
//   x   : current universal assignment (to Skolem block and formula block)
//   y   : existential value presented to the formula block
//   sk  : Skolem block output
//   phi : formula evaluation of (x, y)
// master = controller side, slave = Skolem/formula side.
interface skolem_sweep_ctrl_if #(
  parameter int unsigned N = 8
) ();
  logic [N-1:0] x;
  logic         y;
  logic         sk;
  logic         phi;

  modport master (output x, output y, input sk, input phi);
  modport slave  (input x, input y, output sk, output phi);
endinterface

// File: rtl/skolem_sweep_ctrl_settle_timer.sv
// Loadable down-counter timing each WAIT state.
//   clk, rst_n : clock, async active-low reset
//   load_i     : reload on entry to a WAIT state
//   last_o     : high on the final cycle of the WAIT state
module settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic last_o
);
  import skolem_pkg::*;

  localparam int unsigned SettleEff = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
  localparam int unsigned W = $clog2(SettleEff + 1);
  // Counts SettleEff-1 down to 0; zero marks the last cycle.
  localparam logic [W-1:0] LoadVal = W'(SettleEff - 1);
  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive checker of a Skolem function against its source formula.
// Walks x over all 2^N assignments, feeds y = sk into the formula block and,
// when phi fails, retries with y = ~sk to tell Skolem failures apart from
// points where no y exists.
//   clk, rst_n       : clock, async active-low reset
//   start_i          : begin sweep (only in IDLE/DONE)
//   abort_i          : synchronous abort to IDLE, highest priority
//   stop_on_fail_i   : end at first Skolem failure (latched at start)
//   bus              : x/y out, sk/phi in
//   busy_o, done_o   : status
//   pass/fail/unreal : result counters
//   cex_*            : first failing point
module skolem_sweep_ctrl
  import skolem_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = cnt_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 stop_on_fail_i,
  skolem_sweep_ctrl_if.master  bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     pass_cnt_o,
  output logic [CNT_W-1:0]     fail_cnt_o,
  output logic [CNT_W-1:0]     unreal_cnt_o,
  output logic                 cex_valid_o,
  output logic [N-1:0]         cex_x_o,
  output logic                 cex_sk_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [N-1:0]     XOne   = N'(1);

  sweep_state_t state_d, state_q;
  logic [N-1:0]     x_d, x_q, cex_x_d, cex_x_q;
  logic             y_d, y_q, sk_d, sk_q, stop_d, stop_q;
  logic             cex_valid_d, cex_valid_q, cex_sk_d, cex_sk_q;
  logic [CNT_W-1:0] pass_d, pass_q, fail_d, fail_q, unreal_d, unreal_q;
  logic             tmr_load, tmr_last;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .last_o (tmr_last)
  );

  // Reload the timer whenever a WAIT state is entered.
  assign tmr_load = (state_d != state_q) &&
                    ((state_d == StWaitSk) || (state_d == StWaitPhi) || (state_d == StWaitAlt));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sk_d        = sk_q;
    stop_d      = stop_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    unreal_d    = unreal_q;
    cex_valid_d = cex_valid_q;
    cex_x_d     = cex_x_q;
    cex_sk_d    = cex_sk_q;

    if (abort_i) begin
      // Results stay readable after an abort.
      state_d = StIdle;
      x_d     = '0;
      y_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            pass_d      = '0;
            fail_d      = '0;
            unreal_d    = '0;
            cex_valid_d = 1'b0;
            cex_x_d     = '0;
            cex_sk_d    = 1'b0;
            x_d         = '0;
            stop_d      = stop_on_fail_i;
            state_d     = StWaitSk;
          end
        end
        StWaitSk: begin
          if (tmr_last) begin
            sk_d    = bus.sk;
            y_d     = bus.sk;
            state_d = StWaitPhi;
          end
        end
        StWaitPhi: begin
          if (tmr_last) begin
            if (bus.phi) begin
              pass_d  = pass_q + CntOne;
              state_d = StNext;
            end else begin
              y_d     = ~sk_q;
              state_d = StWaitAlt;
            end
          end
        end
        StWaitAlt: begin
          if (tmr_last) begin
            if (bus.phi) begin
              fail_d = fail_q + CntOne;
              if (!cex_valid_q) begin
                cex_valid_d = 1'b1;
                cex_x_d     = x_q;
                cex_sk_d    = sk_q;
              end
              state_d = stop_q ? StDone : StNext;
            end else begin
              unreal_d = unreal_q + CntOne;
              state_d  = StNext;
            end
          end
        end
        StNext: begin
          if (&x_q) begin
            state_d = StDone;
          end else begin
            x_d     = x_q + XOne;
            state_d = StWaitSk;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= 1'b0;
      sk_q        <= 1'b0;
      stop_q      <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      unreal_q    <= '0;
      cex_valid_q <= 1'b0;
      cex_x_q     <= '0;
      cex_sk_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sk_q        <= sk_d;
      stop_q      <= stop_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      unreal_q    <= unreal_d;
      cex_valid_q <= cex_valid_d;
      cex_x_q     <= cex_x_d;
      cex_sk_q    <= cex_sk_d;
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign busy_o       = (state_q != StIdle) && (state_q != StDone);
  assign done_o       = (state_q == StDone);
  assign pass_cnt_o   = pass_q;
  assign fail_cnt_o   = fail_q;
  assign unreal_cnt_o = unreal_q;
  assign cex_valid_o  = cex_valid_q;
  assign cex_x_o      = cex_x_q;
  assign cex_sk_o     = cex_sk_q;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: instance A (SETTLE=1) with a combinational
// Skolem model, instance B (SETTLE=3) whose Skolem output lags x by 2 cycles.
// The external blocks are described by truth tables: sk_tab[x], and phi(x,y)
// = y ? tab1[x] : tab0[x].
module tb_skolem_sweep_ctrl;

  localparam int CW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  bit [255:0] sk_tab, tab0, tab1;

  skolem_sweep_ctrl_if #(.N(8)) bus_a ();
  skolem_sweep_ctrl_if #(.N(8)) bus_b ();

  assign bus_a.sk  = sk_tab[bus_a.x];
  assign bus_a.phi = bus_a.y ? tab1[bus_a.x] : tab0[bus_a.x];

  logic skd1, skd2;
  always @(posedge clk) begin
    skd1 <= sk_tab[bus_b.x];
    skd2 <= skd1;
  end
  assign bus_b.sk  = skd2;
  assign bus_b.phi = bus_b.y ? tab1[bus_b.x] : tab0[bus_b.x];

  logic start_a = 0, start_b = 0, abort_a = 0, abort_b = 0, stop_on_fail = 0;
  logic busy_a, busy_b, done_a, done_b, cexv_a, cexv_b, cexs_a, cexs_b;
  logic [CW-1:0] pass_a, pass_b, fail_a, fail_b, unreal_a, unreal_b;
  logic [7:0] cexx_a, cexx_b;

  skolem_sweep_ctrl #(.N(8), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
    .stop_on_fail_i(stop_on_fail), .bus(bus_a), .busy_o(busy_a), .done_o(done_a),
    .pass_cnt_o(pass_a), .fail_cnt_o(fail_a), .unreal_cnt_o(unreal_a),
    .cex_valid_o(cexv_a), .cex_x_o(cexx_a), .cex_sk_o(cexs_a)
  );

  skolem_sweep_ctrl #(.N(8), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .stop_on_fail_i(stop_on_fail), .bus(bus_b), .busy_o(busy_b), .done_o(done_b),
    .pass_cnt_o(pass_b), .fail_cnt_o(fail_b), .unreal_cnt_o(unreal_b),
    .cex_valid_o(cexv_b), .cex_x_o(cexx_b), .cex_sk_o(cexs_b)
  );

  // Selected-instance view.
  int sel = 0;
  logic busy_m, done_m, cexv_m, cexs_m, y_m;
  logic [CW-1:0] pass_m, fail_m, unreal_m;
  logic [7:0] cexx_m, x_m;
  always_comb begin
    busy_m = busy_a; done_m = done_a; cexv_m = cexv_a; cexs_m = cexs_a; y_m = bus_a.y;
    pass_m = pass_a; fail_m = fail_a; unreal_m = unreal_a; cexx_m = cexx_a; x_m = bus_a.x;
    if (sel != 0) begin
      busy_m = busy_b; done_m = done_b; cexv_m = cexv_b; cexs_m = cexs_b; y_m = bus_b.y;
      pass_m = pass_b; fail_m = fail_b; unreal_m = unreal_b; cexx_m = cexx_b; x_m = bus_b.x;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic drive_abort(input logic v);
    if (sel == 0) abort_a = v; else abort_b = v;
  endtask

  // Kinds: 0 sk=x0, phi=(y==x0); 1 sk=~x0, same phi; 2 sk=1, phi=(y==1) except
  // unsatisfiable at x=5; 3 random tables.
  task automatic setup_tables(input int kind);
    for (int i = 0; i < 256; i++) begin
      bit b0;
      b0 = (i % 2) == 1;
      case (kind)
        0: begin sk_tab[i] = b0;  tab0[i] = !b0; tab1[i] = b0; end
        1: begin sk_tab[i] = !b0; tab0[i] = !b0; tab1[i] = b0; end
        2: begin sk_tab[i] = 1'b1; tab0[i] = 1'b0; tab1[i] = (i != 5); end
        default: begin
          sk_tab[i] = 1'($urandom_range(0, 1));
          tab0[i]   = 1'($urandom_range(0, 1));
          tab1[i]   = 1'($urandom_range(0, 1));
        end
      endcase
    end
  endtask

  // Reference: classify each point from the tables, accumulate cycle cost.
  task automatic model(input bit stp, input int s, output int p, output int f, output int u,
                       output bit cv, output int cx, output bit cs, output int cyc);
    p = 0; f = 0; u = 0; cv = 0; cx = 0; cs = 0; cyc = 0;
    for (int x = 0; x < 256; x++) begin
      bit sk, ph1, ph2;
      sk  = sk_tab[x];
      ph1 = sk ? tab1[x] : tab0[x];
      ph2 = sk ? tab0[x] : tab1[x];
      if (ph1) begin
        p++; cyc += 2 * s + 1;
      end else if (ph2) begin
        f++;
        if (!cv) begin cv = 1; cx = x; cs = sk; end
        if (stp) begin cyc += 3 * s; break; end
        cyc += 3 * s + 1;
      end else begin
        u++; cyc += 3 * s + 1;
      end
    end
  endtask

  task automatic run_sweep(input bit stp, output int cyc);
    cyc = 0;
    @(negedge clk);
    stop_on_fail = stp;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    while (busy_m && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    check("sweep_timeout", 32'(cyc >= 5000), 0);
  endtask

  typedef struct {
    int kind; int dut; bit stop;
    int pass; int fail; int unreal; bit cexv; int cexx; bit cexs; int busy;
  } scen_t;

  scen_t sc[8];

  initial begin
    int cyc, bound;
    logic [7:0] xs;

    sc[0] = '{0, 0, 0, 256,   0, 0, 0, 0, 0,  768};
    sc[1] = '{1, 0, 0,   0, 256, 0, 1, 0, 1, 1024};
    sc[2] = '{1, 0, 1,   0,   1, 0, 1, 0, 1,    3};
    sc[3] = '{2, 0, 0, 255,   0, 1, 0, 0, 0,  769};
    sc[4] = '{0, 1, 0, 256,   0, 0, 0, 0, 0, 1792};
    sc[5] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    sc[6] = '{3, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    sc[7] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 5; i < 8; i++) sc[i].stop = 1'($urandom_range(0, 1));

    // Reset state.
    rst_n = 1'b0;
    setup_tables(0);
    repeat (2) @(negedge clk);
    check("rst_x", 32'(bus_a.x), 0);
    check("rst_y", 32'(bus_a.y), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_cnts", 32'({pass_a, fail_a, unreal_a}), 0);
    check("rst_cex", 32'({cexv_a, cexx_a, cexs_a}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (sc[i]) begin
      sel = sc[i].dut;
      setup_tables(sc[i].kind);
      if (sc[i].kind == 3) begin
        int p, f, u, cx, cy;
        bit cv, cs;
        model(sc[i].stop, (sel != 0) ? 3 : 1, p, f, u, cv, cx, cs, cy);
        sc[i].pass = p; sc[i].fail = f; sc[i].unreal = u;
        sc[i].cexv = cv; sc[i].cexx = cx; sc[i].cexs = cs; sc[i].busy = cy;
      end
      run_sweep(sc[i].stop, cyc);
      check($sformatf("s%0d_busy_cycles", i), 32'(cyc), 32'(sc[i].busy));
      check($sformatf("s%0d_pass", i), 32'(pass_m), 32'(sc[i].pass));
      check($sformatf("s%0d_fail", i), 32'(fail_m), 32'(sc[i].fail));
      check($sformatf("s%0d_unreal", i), 32'(unreal_m), 32'(sc[i].unreal));
      check($sformatf("s%0d_cex_valid", i), 32'(cexv_m), 32'(sc[i].cexv));
      if (sc[i].cexv) begin
        check($sformatf("s%0d_cex_x", i), 32'(cexx_m), 32'(sc[i].cexx));
        check($sformatf("s%0d_cex_sk", i), 32'(cexs_m), 32'(sc[i].cexs));
      end
      repeat (4) @(negedge clk);
      check($sformatf("s%0d_done_held", i), 32'(done_m), 1);
      check($sformatf("s%0d_pass_held", i), 32'(pass_m), 32'(sc[i].pass));
    end

    // Abort at x = 0x40.
    sel = 0;
    setup_tables(0);
    stop_on_fail = 1'b0;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    bound = 0;
    while (x_m != 8'h40 && bound < 2000) begin bound++; @(negedge clk); end
    check("abort_reach_timeout", 32'(bound >= 2000), 0);
    drive_abort(1'b1);
    @(negedge clk);
    drive_abort(1'b0);
    check("abort_busy", 32'(busy_m), 0);
    check("abort_done", 32'(done_m), 0);
    check("abort_x", 32'(x_m), 0);
    check("abort_y", 32'(y_m), 0);
    check("abort_pass_hold", 32'(pass_m), 64);

    // Start pulse while busy is ignored.
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    repeat (50) @(negedge clk);
    xs = x_m;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    check("restart_ignored_x", 32'(x_m >= xs && xs != 0), 1);
    check("restart_ignored_busy", 32'(busy_m), 1);
    bound = 0;
    while (!done_m && bound < 2000) begin bound++; @(negedge clk); end
    check("restart_done_timeout", 32'(bound >= 2000), 0);
    check("restart_pass", 32'(pass_m), 256);

    // Start and abort together in DONE: abort wins, results held.
    drive_start(1'b1);
    drive_abort(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    drive_abort(1'b0);
    check("abort_start_done", 32'(done_m), 0);
    check("abort_start_busy", 32'(busy_m), 0);
    check("abort_start_pass", 32'(pass_m), 256);

    // Async reset mid-sweep.
    setup_tables(1);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    bound = 0;
    while (fail_m < 3 && bound < 2000) begin bound++; @(negedge clk); end
    check("rstmid_reach_timeout", 32'(bound >= 2000), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy_m), 0);
    check("rstmid_x_y", 32'({x_m, y_m}), 0);
    check("rstmid_cnts", 32'({pass_m, fail_m, unreal_m}), 0);
    check("rstmid_cex", 32'({cexv_m, cexx_m, cexs_m}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
